// File: rtl/pc_seq_pkg.sv
// Shared types for the program-flow sequencer: FSM states, flow-op encoding
// and the flow-op priority resolver.
package pc_seq_pkg;

    localparam logic [15:0] DEF_RESET_VECTOR = 16'h0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OP_SEQ  = 2'd0,
        OP_JUMP = 2'd1,
        OP_CALL = 2'd2,
        OP_RET  = 2'd3
    } flow_op_e;

    // ret beats call beats jump; anything lower than the winner is dropped
    function automatic flow_op_e resolve_flow(input logic ret, input logic call,
                                              input logic jump);
        if (ret)       return OP_RET;
        else if (call) return OP_CALL;
        else if (jump) return OP_JUMP;
        else           return OP_SEQ;
    endfunction

endpackage

// File: rtl/pc_return_stack.sv
// LIFO of return addresses; one push or one pop per cycle, guarded by full/empty.
module pc_return_stack #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] dout,
    output logic              full,
    output logic              empty
);
    localparam int IW = $clog2(DEPTH);

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [IW:0]       sp_q;
    logic [IW-1:0]     top_idx;

    // Wraps to DEPTH-1 when sp==DEPTH, which is exactly the top entry
    assign top_idx = sp_q[IW-1:0] - IW'(1);
    assign dout    = mem_q[top_idx];
    assign full    = (sp_q == (IW+1)'(DEPTH));
    assign empty   = (sp_q == '0);

    always_ff @(posedge clock) begin
        if (reset)
            sp_q <= '0;
        else if (push && !full)
            sp_q <= sp_q + (IW+1)'(1);
        else if (pop && !empty)
            sp_q <= sp_q - (IW+1)'(1);
    end

    always_ff @(posedge clock) begin
        if (!reset && push && !full)
            mem_q[sp_q[IW-1:0]] <= din;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner: fetches over req/ack, hands the word to execute,
// then advances the PC by sequential/jump/call/return with a hardware stack.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                 ADDR_W       = 16,
    parameter int                 DATA_W       = 16,
    parameter int                 STACK_DEPTH  = 4,
    parameter logic [ADDR_W-1:0]  RESET_VECTOR = ADDR_W'(DEF_RESET_VECTOR)
) (
    input  logic              clock,
    input  logic              reset,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              exec_done,
    input  logic              jump_en,
    input  logic              call_en,
    input  logic              ret_en,
    input  logic              halt_req,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              fault
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              mem_req_q;
    logic              push, pop, stk_full, stk_empty;
    logic [ADDR_W-1:0] stk_dout;
    flow_op_e          op;

    assign pc_inc = pc_q + ADDR_W'(1);
    assign op     = resolve_flow(ret_en, call_en, jump_en);

    pc_return_stack #(.DEPTH(STACK_DEPTH), .ADDR_W(ADDR_W)) u_stack (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .dout  (stk_dout),
        .full  (stk_full),
        .empty (stk_empty)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        push    = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            // mem_req is low for the first FETCH cycle after reset; no ack taken then
            ST_FETCH: if (mem_req_q && mem_ack) begin
                instr_d = mem_rdata;
                state_d = ST_EXEC;
            end
            ST_EXEC: if (exec_done) begin
                state_d = halt_req ? ST_HALT : ST_FETCH;
                unique case (op)
                    OP_SEQ:  pc_d = pc_inc;
                    OP_JUMP: pc_d = target;
                    OP_CALL: if (stk_full) state_d = ST_FAULT;
                             else begin push = 1'b1; pc_d = target; end
                    OP_RET:  if (stk_empty) state_d = ST_FAULT;
                             else begin pop = 1'b1; pc_d = stk_dout; end
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_VECTOR;
            instr_q   <= '0;
            mem_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            mem_req_q <= (state_d == ST_FETCH);
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = (state_q == ST_EXEC);
    assign halted      = (state_q == ST_HALT) || (state_q == ST_FAULT);
    assign fault       = (state_q == ST_FAULT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized + directed bench for pc_sequencer against a queue-based flow model.
module tb_pc_sequencer;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req, mem_ack = 1'b0;
    logic [15:0] mem_addr, mem_rdata = '0, instr, target = '0, pc;
    logic        instr_valid, halted, fault;
    logic        exec_done = 1'b0, jump_en = 1'b0, call_en = 1'b0;
    logic        ret_en = 1'b0, halt_req = 1'b0;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    pc_sequencer dut (
        .clock(clock), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instr(instr),
        .instr_valid(instr_valid), .exec_done(exec_done), .jump_en(jump_en),
        .call_en(call_en), .ret_en(ret_en), .halt_req(halt_req), .target(target),
        .pc(pc), .halted(halted), .fault(fault)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: phase of the fetch/execute loop, PC, latched word, return queue
    localparam int P_IDLE = 0, P_FETCH = 1, P_EXEC = 2, P_HALT = 3, P_FAULT = 4;
    int          m_phase = P_IDLE;
    logic [15:0] m_pc = '0, m_instr = '0;
    logic [15:0] m_stk[$];

    always @(posedge clock) begin
        if (reset) begin
            m_phase = P_IDLE; m_pc = 16'h0000; m_instr = '0; m_stk.delete();
        end else begin
            case (m_phase)
                P_IDLE:  m_phase = P_FETCH;
                P_FETCH: if (mem_ack) begin m_instr = mem_rdata; m_phase = P_EXEC; end
                P_EXEC: if (exec_done) begin
                    if (ret_en) begin
                        if (m_stk.size() == 0) m_phase = P_FAULT;
                        else m_pc = m_stk.pop_back();
                    end else if (call_en) begin
                        if (m_stk.size() == 4) m_phase = P_FAULT;
                        else begin m_stk.push_back(m_pc + 16'd1); m_pc = target; end
                    end else if (jump_en) m_pc = target;
                    else m_pc = m_pc + 16'd1;
                    if (m_phase != P_FAULT) m_phase = halt_req ? P_HALT : P_FETCH;
                end
                default: ;
            endcase
        end
    end

    always @(negedge clock) begin
        if (started) begin
            chk("mem_req", mem_req, m_phase == P_FETCH);
            if (m_phase == P_FETCH) chk("mem_addr", mem_addr, m_pc);
            chk("pc", pc, m_pc);
            chk("instr", instr, m_instr);
            chk("instr_valid", instr_valid, m_phase == P_EXEC);
            chk("halted", halted, m_phase == P_HALT || m_phase == P_FAULT);
            chk("fault", fault, m_phase == P_FAULT);
        end
    end

    task automatic step();
        @(posedge clock); #1;
    endtask

    task automatic clear_flow();
        exec_done = 0; ret_en = 0; call_en = 0; jump_en = 0; halt_req = 0; mem_ack = 0;
    endtask

    task automatic do_reset(input int n);
        reset = 1; clear_flow();
        repeat (n) begin step(); started = 1'b1; end
        reset = 0;
    endtask

    task automatic do_fetch(input bit ca, input logic [15:0] ea, input int wd,
                            input logic [15:0] w);
        int n = 0;
        while (!mem_req && n < 20) begin step(); n++; end
        if (!mem_req) begin chk("fetch_timeout", 0, 1); return; end
        if (ca) chk("fetch_addr_lit", mem_addr, ea);
        repeat (wd) begin mem_ack = 0; mem_rdata = 16'($urandom); step(); end
        mem_ack = 1; mem_rdata = w; step(); mem_ack = 0;
        if (ca) chk("instr_lit", instr, w);
    endtask

    task automatic do_exec(input int d, input bit r, input bit c, input bit j,
                           input bit h, input logic [15:0] t);
        int n = 0;
        while (!instr_valid && n < 20) begin step(); n++; end
        if (!instr_valid) begin chk("exec_timeout", 0, 1); return; end
        // Flow inputs and stray acks without exec_done must be ignored
        repeat (d) begin
            exec_done = 0; ret_en = 1'($urandom); call_en = 1'($urandom);
            jump_en = 1'($urandom); halt_req = 1'($urandom);
            target = 16'($urandom); mem_ack = 1'($urandom); step();
        end
        exec_done = 1; ret_en = r; call_en = c; jump_en = j; halt_req = h;
        target = t; mem_ack = 0; step(); clear_flow();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset(2);
        chk("rst_pc_lit", pc, 16'h0000);
        chk("rst_req_lit", mem_req, 0);
        step();
        chk("post_rst_req_lit", mem_req, 1);
        for (int i = 0; i < 3; i++) begin
            do_fetch(1, 16'(i), 0, 16'hA000 + 16'(i));
            do_exec(1, 0, 0, 0, 0, 16'h0);
        end
        do_fetch(1, 16'h0003, 0, 16'hB003);
        do_exec(0, 0, 0, 1, 0, 16'h0100);
        chk("jump_pc_lit", pc, 16'h0100);
        do_fetch(1, 16'h0100, 2, 16'hB100);
        do_exec(1, 0, 0, 1, 0, 16'h0010);
        do_fetch(1, 16'h0010, 0, 16'hC010);
        do_exec(0, 0, 1, 0, 0, 16'h0200);
        do_fetch(1, 16'h0200, 1, 16'hC200);
        do_exec(2, 1, 1, 1, 0, 16'h0777);
        do_fetch(1, 16'h0011, 0, 16'hC011);
        do_exec(0, 0, 0, 0, 0, 16'h0);

        // Overflow on the fifth nested call
        do_reset(1);
        do_fetch(1, 16'h0000, 0, 16'h1);
        do_exec(0, 0, 1, 0, 0, 16'h0300);
        for (int k = 0; k < 3; k++) begin
            do_fetch(1, 16'h0300 + 16'(k), 0, 16'h2);
            do_exec(0, 0, 1, 0, 0, 16'h0301 + 16'(k));
        end
        do_fetch(1, 16'h0303, 0, 16'h3);
        do_exec(0, 0, 1, 0, 1, 16'h0999);
        chk("ovf_fault_lit", fault, 1);
        chk("ovf_pc_lit", pc, 16'h0303);
        chk("ovf_req_lit", mem_req, 0);
        repeat (3) step();

        // Underflow
        do_reset(1);
        do_fetch(1, 16'h0000, 0, 16'h4);
        do_exec(0, 1, 0, 0, 0, 16'h0);
        chk("udf_fault_lit", fault, 1);
        chk("udf_pc_lit", pc, 16'h0000);

        // Wrap of sequential increment and of the pushed return address
        do_reset(1);
        do_fetch(1, 16'h0000, 0, 16'h5);
        do_exec(0, 0, 0, 1, 0, 16'hFFFF);
        do_fetch(1, 16'hFFFF, 0, 16'h6);
        do_exec(0, 0, 0, 0, 0, 16'h0);
        do_fetch(1, 16'h0000, 0, 16'h7);
        do_exec(0, 0, 0, 1, 0, 16'hFFFF);
        do_fetch(1, 16'hFFFF, 0, 16'h8);
        do_exec(0, 0, 1, 0, 0, 16'h0400);
        do_fetch(1, 16'h0400, 0, 16'h9);
        do_exec(0, 1, 0, 0, 0, 16'h0);
        do_fetch(1, 16'h0000, 0, 16'hA);

        // Halt still applies the flow update
        do_reset(1);
        do_fetch(1, 16'h0000, 0, 16'hB);
        do_exec(0, 0, 0, 1, 0, 16'h0005);
        do_fetch(1, 16'h0005, 0, 16'hC);
        do_exec(0, 0, 0, 0, 1, 16'h0);
        chk("halt_pc_lit", pc, 16'h0006);
        chk("halt_flag_lit", halted, 1);
        repeat (3) step();
        chk("halt_req_lit", mem_req, 0);

        // Reset during a fetch whose ack is withheld
        do_reset(1);
        do_fetch(1, 16'h0000, 0, 16'hD);
        do_exec(0, 0, 0, 1, 0, 16'h0050);
        repeat (3) step();
        chk("pend_addr_lit", mem_addr, 16'h0050);
        reset = 1; step();
        chk("pend_rst_pc_lit", pc, 16'h0000);
        chk("pend_rst_iv_lit", instr_valid, 0);
        reset = 0;
        do_fetch(1, 16'h0000, 0, 16'hE);

        // Randomized flow against the model
        do_reset(1);
        repeat (300) begin
            if (halted || ($urandom % 40) == 0) do_reset(1 + ($urandom % 2));
            else begin
                do_fetch(0, 16'h0, $urandom_range(0, 3), 16'($urandom));
                do_exec($urandom_range(0, 3), ($urandom % 5) == 0, ($urandom % 4) == 0,
                        ($urandom % 4) == 0, ($urandom % 25) == 0, 16'($urandom));
            end
        end
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
